io_input_conditioner: RTL and testbench

Conditions the raw board inputs (slide switches and push-buttons) into the two 32-bit words the data memory's I/O read path returns for the input-port addresses. Inputs are two-flop synchronized and per-bit debounced. Key presses are also latched into sticky event flags, so the CPU can poll for a press that has already been released. The block sits directly upstream of the I/O input register, and its outputs drive `in_port0` and `in_port1` unchanged.

---
 rtl/io_input_conditioner.sv | 133 +++++++++++++
 tb/tb_io_input_conditioner.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/io_input_conditioner.sv
// io_input_conditioner
//   Turns raw board switches and push-buttons into the two 32-bit words the
//   data memory returns for the input-port addresses. Every bit gets a
//   two-flop synchronizer and a consecutive-sample debouncer. Key presses
//   also set sticky event flags, so the CPU can poll for a press that has
//   already been released.
//
// Ports
//   clock      : system clock, rising edge
//   resetn     : synchronous active-low reset
//   sw_raw     : [SW_W]  asynchronous switch levels, 1 = on
//   key_raw_n  : [KEY_W] asynchronous key levels, 0 = pressed
//   event_clr  : one-cycle pulse, clears every sticky press flag
//   in_port0   : [32] {zeros, debounced switches}
//   in_port1   : [32] [KEY_W-1:0] debounced keys (1 = pressed),
//                     [8+KEY_W-1:8] sticky press flags, rest 0

// Per-bit channel: synchronizer + debounce counter.
//   stable : debounced level (register)
//   rise   : stable goes 0->1 on the coming edge (combinational)
module ioc_channel #(
  parameter int N = 4
) (
  input  logic clock,
  input  logic resetn,
  input  logic raw,
  output logic stable,
  output logic rise
);
  localparam int CNT_W = $clog2(N);
  localparam logic [CNT_W-1:0] TERM = CNT_W'(N - 1);

  // Action taken on the coming edge. COMMIT is transient: the level is
  // accepted and the channel is back in IDLE on the same edge, so the
  // counter alone carries the state.
  typedef enum logic [1:0] {IDLE, COUNTING, COMMIT} act_e;

  logic             s1_q, s2_q;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  act_e             act;

  always_comb begin
    act = IDLE;
    if (s2_q != stable_q) act = (cnt_q == TERM) ? COMMIT : COUNTING;
  end

  // A match always drops the count, so only N back-to-back mismatching
  // samples get through; the counter never exceeds N-1.
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    unique case (act)
      COUNTING: cnt_d    = cnt_q + 1'b1;
      COMMIT:   stable_d = s2_q;
      default:  ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      s1_q     <= raw;
      s2_q     <= s1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable = stable_q;
  assign rise   = stable_d & ~stable_q;
endmodule

module io_input_conditioner #(
  parameter int SW_W            = 10,
  parameter int KEY_W           = 4,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [SW_W-1:0]  sw_raw,
  input  logic [KEY_W-1:0] key_raw_n,
  input  logic             event_clr,
  output logic [31:0]      in_port0,
  output logic [31:0]      in_port1
);
  logic [SW_W-1:0]  sw_stable, sw_rise_unused;
  logic [KEY_W-1:0] key_p, key_stable, key_rise;
  logic [KEY_W-1:0] key_event_q, key_event_d;

  // Keys are active-low on the board; everything downstream is active-high.
  assign key_p = ~key_raw_n;

  ioc_channel #(.N(DEBOUNCE_CYCLES)) u_sw [SW_W-1:0] (
    .clock  (clock),
    .resetn (resetn),
    .raw    (sw_raw),
    .stable (sw_stable),
    .rise   (sw_rise_unused)
  );

  ioc_channel #(.N(DEBOUNCE_CYCLES)) u_key [KEY_W-1:0] (
    .clock  (clock),
    .resetn (resetn),
    .raw    (key_p),
    .stable (key_stable),
    .rise   (key_rise)
  );

  // The set term is OR-ed in after the clear, so a press committing on the
  // same edge as a clear keeps its flag.
  always_comb begin
    key_event_d = (key_event_q & ~{KEY_W{event_clr}}) | key_rise;
  end

  always_ff @(posedge clock) begin
    if (!resetn) key_event_q <= '0;
    else         key_event_q <= key_event_d;
  end

  // Outputs come from registers only; no raw input reaches them directly.
  always_comb begin
    in_port0                 = '0;
    in_port0[SW_W-1:0]       = sw_stable;
    in_port1                 = '0;
    in_port1[KEY_W-1:0]      = key_stable;
    in_port1[8 +: KEY_W]     = key_event_q;
  end
endmodule

// File: tb/tb_io_input_conditioner.sv
module tb_io_input_conditioner;
  localparam int SW_W  = 10;
  localparam int KEY_W = 4;
  localparam int N     = 4;
  localparam int NB    = SW_W + KEY_W;

  logic             clock;
  logic             resetn;
  logic [SW_W-1:0]  sw_raw;
  logic [KEY_W-1:0] key_raw_n;
  logic             event_clr;
  logic [31:0]      in_port0, in_port1;

  int n_chk  = 0;
  int n_fail = 0;

  io_input_conditioner #(
    .SW_W(SW_W), .KEY_W(KEY_W), .DEBOUNCE_CYCLES(N)
  ) dut (
    .clock     (clock),
    .resetn    (resetn),
    .sw_raw    (sw_raw),
    .key_raw_n (key_raw_n),
    .event_clr (event_clr),
    .in_port0  (in_port0),
    .in_port1  (in_port1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: a level is accepted once the last N samples seen
  // after the two-stage delay all differ from the accepted level.
  bit [NB-1:0]    m_d1, m_d2, m_stable;
  bit [KEY_W-1:0] m_ev;
  bit             hist [NB][$];

  task automatic model_edge();
    bit [NB-1:0]    raw, seen;
    bit [KEY_W-1:0] old_keys, rise;
    if (!resetn) begin
      m_d1 = '0; m_d2 = '0; m_stable = '0; m_ev = '0;
      for (int b = 0; b < NB; b++) hist[b].delete();
      return;
    end
    raw  = {~key_raw_n, sw_raw};
    seen = m_d2;
    m_d2 = m_d1;
    m_d1 = raw;
    old_keys = m_stable[NB-1:SW_W];
    for (int b = 0; b < NB; b++) begin
      hist[b].push_back(seen[b]);
      if (hist[b].size() > N) void'(hist[b].pop_front());
      if (hist[b].size() == N) begin
        int d = 0;
        for (int j = 0; j < N; j++) if (hist[b][j] != m_stable[b]) d++;
        if (d == N) m_stable[b] = ~m_stable[b];
      end
    end
    rise = m_stable[NB-1:SW_W] & ~old_keys;
    m_ev = event_clr ? rise : (m_ev | rise);
  endtask

  function automatic logic [31:0] exp0();
    return {{(32-SW_W){1'b0}}, m_stable[SW_W-1:0]};
  endfunction

  function automatic logic [31:0] exp1();
    return {16'h0, 4'h0, m_ev, 4'h0, m_stable[NB-1:SW_W]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // One clock edge: advance the model with the inputs the DUT sampled,
  // then compare both ports just after the edge.
  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
    check("model_p0", in_port0, exp0());
    check("model_p1", in_port1, exp1());
  endtask

  initial begin
    resetn = 1'b0; sw_raw = 10'h3FF; key_raw_n = 4'h0; event_clr = 1'b0;

    // reset with every input active
    repeat (3) begin
      step();
      check("rst_p0", in_port0, 32'h0);
      check("rst_p1", in_port1, 32'h0);
    end
    resetn = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      step();
      if (e < 6) check("rst_lat_p0", in_port0, 32'h0);
    end
    check("rst_p0_after", in_port0, 32'h3FF);
    check("rst_p1_after", in_port1, 32'h0F0F);

    // release everything: flags stay, then a clear drops them
    sw_raw = '0; key_raw_n = 4'hF;
    repeat (8) step();
    check("release_p1", in_port1, 32'h0F00);
    event_clr = 1'b1; step(); event_clr = 1'b0;
    check("clr_all", in_port1, 32'h0);

    // 3-cycle glitch on sw[0] is rejected
    sw_raw[0] = 1'b1;
    repeat (3) begin step(); check("glitch_p0", in_port0, 32'h0); end
    sw_raw[0] = 1'b0;
    repeat (8) begin step(); check("glitch_p0", in_port0, 32'h0); end

    // latency: edges k..k+4 still 0, after k+5 the new word
    sw_raw = 10'h155;
    repeat (5) begin step(); check("lat_hold", in_port0, 32'h0); end
    step();
    check("lat_new", in_port0, 32'h155);

    // press key 2 for 10 cycles, then release
    key_raw_n = 4'b1011;
    repeat (10) step();
    check("press_p1", in_port1, 32'h0404);
    key_raw_n = 4'hF;
    repeat (8) step();
    check("released_p1", in_port1, 32'h0400);

    // clear with flags 0100
    event_clr = 1'b1; step(); event_clr = 1'b0;
    check("clr_k2", in_port1, 32'h0);

    // clear on the same edge the key-1 press commits: set wins
    key_raw_n = 4'b1101;
    repeat (5) step();
    check("coll_pre", in_port1, 32'h0);
    event_clr = 1'b1; step(); event_clr = 1'b0;
    check("coll_set", in_port1, 32'h0202);
    key_raw_n = 4'hF;
    repeat (8) step();
    check("coll_after", in_port1, 32'h0200);

    // reset in the middle of a count discards it
    sw_raw = 10'h2AA;
    repeat (4) step();
    resetn = 1'b0; step(); resetn = 1'b1;
    check("midrst_p0", in_port0, 32'h0);
    check("midrst_p1", in_port1, 32'h0);
    repeat (5) begin step(); check("midrst_hold", in_port0, 32'h0); end
    step();
    check("midrst_new", in_port0, 32'h2AA);

    // random levels with mixed hold lengths, clears and rare resets
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 4) == 0) sw_raw    = SW_W'($urandom);
      if ($urandom_range(0, 4) == 0) key_raw_n = KEY_W'($urandom);
      event_clr = ($urandom_range(0, 11) == 0);
      resetn    = ($urandom_range(0, 149) != 0);
      step();
    end
    resetn = 1'b1; event_clr = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
